// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM request arbiter: owner encoding and access sizes.
package sram_arb_pkg;

   // Owner tag stored per outstanding transaction
   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   // Access size encodings on the *_size buses
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_req_arbiter_owner_fifo.sv
// owner_fifo: 1-bit-wide circular FIFO remembering which requester owns each
// outstanding memory transaction, oldest first.
module owner_fifo #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic dout,
   output logic full,
   output logic empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] store_reg;
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;

   // Pointers wrap at DEPTH, which need not be a power of two
   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Pointer and occupancy bookkeeping; push and pop together leave count unchanged
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= bump(wr_ptr_reg);
         if (pop)  rd_ptr_reg <= bump(rd_ptr_reg);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Owner storage; contents are meaningless until written so no reset is needed
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (push && (wr_ptr_reg == PW'(i))) store_reg[i] <= din;
      end
   end

   assign dout  = store_reg[rd_ptr_reg];
   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);

endmodule

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like port between instruction-fetch and data
// requesters, locks a stalled grant until accepted, and routes in-order responses
// back to their owners. Optional macro SRAM_ARB_ROUND_ROBIN_EN selects
// round-robin arbitration; otherwise data has fixed priority over inst.
module sram_req_arbiter
   import sram_arb_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata,
   output logic        arb_err
);

   logic lock_valid_reg;
   logic lock_owner_reg;
   logic arb_err_reg;
   logic grant;
   logic granted_req;
   logic pop_ok;
   logic full_eff;
   logic accept;
   logic fifo_head;
   logic fifo_full;
   logic fifo_empty;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic last_grant_reg;
`endif

   // Grant selection: a held lock wins, then a lone requester, then the tie-break rule
   always_comb begin
      grant = OWN_INST;
      if (lock_valid_reg) begin
         grant = lock_owner_reg;
      end else if (inst_req && !data_req) begin
         grant = OWN_INST;
      end else if (data_req && !inst_req) begin
         grant = OWN_DATA;
      end else if (inst_req && data_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         grant = ~last_grant_reg;
`else
         grant = OWN_DATA;
`endif
      end
   end

   assign granted_req = (grant == OWN_DATA) ? data_req : inst_req;

   // A response arriving this cycle frees a slot, so a full FIFO can still accept
   assign pop_ok   = mem_data_ok & ~fifo_empty;
   assign full_eff = fifo_full & ~pop_ok;
   assign mem_req  = resetn & granted_req & ~full_eff;
   assign accept   = mem_req & mem_addr_ok;

   assign inst_addr_ok = accept & (grant == OWN_INST);
   assign data_addr_ok = accept & (grant == OWN_DATA);

   assign mem_wr    = (grant == OWN_DATA) ? data_wr    : inst_wr;
   assign mem_size  = (grant == OWN_DATA) ? data_size  : inst_size;
   assign mem_addr  = (grant == OWN_DATA) ? data_addr  : inst_addr;
   assign mem_wstrb = (grant == OWN_DATA) ? data_wstrb : inst_wstrb;
   assign mem_wdata = (grant == OWN_DATA) ? data_wdata : inst_wdata;

   assign inst_data_ok = resetn & pop_ok & (fifo_head == OWN_INST);
   assign data_data_ok = resetn & pop_ok & (fifo_head == OWN_DATA);
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;
   assign arb_err      = arb_err_reg;

   // Grant lock: hold a stalled grant until accepted; an abandoned request breaks it
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_valid_reg <= 1'b0;
         lock_owner_reg <= OWN_INST;
      end else if (accept) begin
         lock_valid_reg <= 1'b0;
      end else if (lock_valid_reg && !granted_req) begin
         lock_valid_reg <= 1'b0;
      end else if (mem_req && !mem_addr_ok) begin
         lock_valid_reg <= 1'b1;
         lock_owner_reg <= grant;
      end
   end

   // Sticky protocol-violation flag: orphan response or dropped locked request
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         arb_err_reg <= 1'b0;
      end else if ((mem_data_ok && fifo_empty) || (lock_valid_reg && !granted_req)) begin
         arb_err_reg <= 1'b1;
      end
   end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   // Remember the most recently accepted owner for the round-robin tie-break
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_grant_reg <= OWN_INST;
      end else if (accept) begin
         last_grant_reg <= grant;
      end
   end
`endif

   owner_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (accept),
      .pop    (pop_ok),
      .din    (grant),
      .dout   (fifo_head),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Testbench for sram_req_arbiter: directed scenarios followed by randomized
// traffic, all checked against a queue-based reference model.
module tb_sram_req_arbiter;
   import sram_arb_pkg::*;

   localparam int MAXO = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ireq, iwr, dreq, dwr;
   logic [1:0]  isize, dsize;
   logic [31:0] iaddr, iwdata, daddr, dwdata;
   logic [3:0]  iwstrb, dwstrb;
   logic        maok, mdok;
   logic [31:0] mrdata;

   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        arb_err;

   always #5 clk = ~clk;

   sram_req_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .inst_req     (ireq),
      .inst_wr      (iwr),
      .inst_size    (isize),
      .inst_addr    (iaddr),
      .inst_wstrb   (iwstrb),
      .inst_wdata   (iwdata),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (dreq),
      .data_wr      (dwr),
      .data_size    (dsize),
      .data_addr    (daddr),
      .data_wstrb   (dwstrb),
      .data_wdata   (dwdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .mem_req      (mem_req),
      .mem_wr       (mem_wr),
      .mem_size     (mem_size),
      .mem_addr     (mem_addr),
      .mem_wstrb    (mem_wstrb),
      .mem_wdata    (mem_wdata),
      .mem_addr_ok  (maok),
      .mem_data_ok  (mdok),
      .mem_rdata    (mrdata),
      .arb_err      (arb_err)
   );

   int compared   = 0;
   int mismatched = 0;

   // Reference model state: outstanding owners in issue order plus lock/err/last
   bit q[$];
   bit m_lock_v, m_lock_o, m_last, m_err;
   bit acc_i, acc_d;
   // Observations captured mid-cycle for directed constant checks
   logic s_mreq, s_iaok, s_daok, s_idok, s_ddok;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit rr_en();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // One clock cycle: compare outputs against the model mid-cycle, then advance it
   task automatic cycle();
      bit pop_ok, g, greq, mreq, acc;
      int slots;
      @(negedge clk);
      pop_ok = mdok && (q.size() > 0);
      slots  = MAXO - q.size() + (pop_ok ? 1 : 0);
      if (m_lock_v)            g = m_lock_o;
      else if (ireq && !dreq)  g = 1'b0;
      else if (dreq && !ireq)  g = 1'b1;
      else if (ireq && dreq)   g = rr_en() ? !m_last : 1'b1;
      else                     g = 1'b0;
      greq = g ? dreq : ireq;
      mreq = greq && (slots > 0);
      acc  = mreq && maok;

      s_mreq = mem_req; s_iaok = inst_addr_ok; s_daok = data_addr_ok;
      s_idok = inst_data_ok; s_ddok = data_data_ok;

      chk("mem_req", mem_req, mreq);
      chk("inst_addr_ok", inst_addr_ok, acc && !g);
      chk("data_addr_ok", data_addr_ok, acc && g);
      if (mreq) begin
         chk("mem_wr",    mem_wr,    g ? dwr    : iwr);
         chk("mem_size",  mem_size,  g ? dsize  : isize);
         chk("mem_addr",  mem_addr,  g ? daddr  : iaddr);
         chk("mem_wstrb", mem_wstrb, g ? dwstrb : iwstrb);
         chk("mem_wdata", mem_wdata, g ? dwdata : iwdata);
      end
      chk("inst_data_ok", inst_data_ok, pop_ok && (q[0] == 1'b0));
      chk("data_data_ok", data_data_ok, pop_ok && (q[0] == 1'b1));
      if (pop_ok) begin
         if (q[0]) chk("data_rdata", data_rdata, mrdata);
         else      chk("inst_rdata", inst_rdata, mrdata);
         $display("RESP   owner=%s rdata=0x%08h t=%0t", q[0] ? "data" : "inst", mrdata, $time);
      end
      if (acc)
         $display("ACCEPT owner=%s wr=%0b addr=0x%08h t=%0t", g ? "data" : "inst",
                  g ? dwr : iwr, g ? daddr : iaddr, $time);

      if (mdok && !pop_ok) m_err = 1'b1;
      if (m_lock_v && !greq) m_err = 1'b1;
      if (acc)                    m_lock_v = 1'b0;
      else if (m_lock_v && !greq) m_lock_v = 1'b0;
      else if (mreq && !maok) begin m_lock_v = 1'b1; m_lock_o = g; end
      if (pop_ok) void'(q.pop_front());
      if (acc) q.push_back(g);
      if (acc && rr_en()) m_last = g;
      acc_i = acc && !g;
      acc_d = acc && g;
      @(posedge clk);
      #1;
      chk("arb_err", arb_err, m_err);
   endtask

   task automatic idle_inputs();
      ireq = 0; iwr = 0; isize = SZ_WORD; iaddr = 0; iwstrb = 0; iwdata = 0;
      dreq = 0; dwr = 0; dsize = SZ_WORD; daddr = 0; dwstrb = 0; dwdata = 0;
      maok = 0; mdok = 0; mrdata = 0;
   endtask

   // Reset with traffic present: outputs must be quiet while reset is low
   task automatic do_reset();
      ireq = 1; dreq = 1; maok = 1; mdok = 1;
      resetn = 1'b0;
      #2;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_inst_addr_ok", inst_addr_ok, 0);
      chk("rst_data_addr_ok", data_addr_ok, 0);
      chk("rst_inst_data_ok", inst_data_ok, 0);
      chk("rst_data_data_ok", data_data_ok, 0);
      chk("rst_arb_err", arb_err, 0);
      q.delete(); m_lock_v = 0; m_lock_o = 0; m_last = 0; m_err = 0;
      @(posedge clk);
      #1;
      idle_inputs();
      resetn = 1'b1;
   endtask

   task automatic drain();
      ireq = 0; dreq = 0;
      for (int n = 0; n < 20 && q.size() > 0; n++) begin
         mdok = 1; mrdata = $urandom;
         cycle();
      end
      mdok = 0;
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      idle_inputs();
      resetn = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Single inst read with a response one cycle later
      ireq = 1; iaddr = 32'h1c00_0000; isize = SZ_WORD; maok = 1;
      cycle();
      chk("t1_inst_addr_ok", s_iaok, 1);
      ireq = 0; mdok = 1; mrdata = 32'h0280_0000;
      cycle();
      chk("t1_inst_data_ok", s_idok, 1);
      chk("t1_data_data_ok", s_ddok, 0);
      mdok = 0;

      // Both requesters continuously active
      do_reset();
      ireq = 1; iaddr = 32'h1000; dreq = 1; daddr = 32'h2000; maok = 1;
      for (int k = 0; k < 6; k++) begin
         mdok = (q.size() > 0); mrdata = $urandom;
         cycle();
         if (rr_en()) chk("t2_rr_data_grant", s_daok, (k % 2 == 0) ? 1 : 0);
         else         chk("t2_fixed_data_grant", s_daok, 1);
      end
      drain();

      // Stalled inst request keeps its lock while data arrives
      do_reset();
      ireq = 1; iaddr = 32'h3000; maok = 0;
      cycle();
      dreq = 1; daddr = 32'h4000;
      cycle();
      cycle();
      maok = 1;
      cycle();
      chk("t3_inst_accept", s_iaok, 1);
      chk("t3_data_wait", s_daok, 0);
      ireq = 0;
      cycle();
      chk("t3_data_accept", s_daok, 1);
      dreq = 0;
      drain();

      // FIFO full, then a pop lets a third request in the same cycle
      do_reset();
      ireq = 1; iaddr = 32'h5000; maok = 1;
      cycle();
      iaddr = 32'h5004;
      cycle();
      iaddr = 32'h5008;
      cycle();
      chk("t4_full_mem_req", s_mreq, 0);
      chk("t4_full_addr_ok", s_iaok, 0);
      mdok = 1; mrdata = 32'h1111_2222;
      cycle();
      chk("t4_swap_accept", s_iaok, 1);
      ireq = 1; iaddr = 32'h500c; mdok = 0;
      cycle();
      chk("t4_still_full", s_mreq, 0);
      drain();

      // Data write then inst read, responses in issue order
      do_reset();
      dreq = 1; dwr = 1; dwstrb = 4'hF; dwdata = 32'hDEAD_BEEF; daddr = 32'h6000; maok = 1;
      cycle();
      dreq = 0; ireq = 1; iaddr = 32'h7000;
      cycle();
      ireq = 0; mdok = 1; mrdata = 32'h0;
      cycle();
      chk("t5_first_data", s_ddok, 1);
      mrdata = 32'hCAFE_0001;
      cycle();
      chk("t5_second_inst", s_idok, 1);
      mdok = 0;

      // Orphan response sets a sticky error, cleared only by reset
      mdok = 1; mrdata = 32'h1234_5678;
      cycle();
      chk("t6_no_inst_pulse", s_idok, 0);
      chk("t6_no_data_pulse", s_ddok, 0);
      mdok = 0;
      cycle();
      cycle();
      chk("t6_err_sticky", arb_err, 1);
      do_reset();
      cycle();

      // Randomized protocol-abiding traffic
      for (int n = 0; n < 1500; n++) begin
         if (acc_i || !ireq) begin
            ireq = ($urandom_range(0, 2) != 0);
            iwr = $urandom; isize = 2'($urandom_range(0, 2)); iaddr = $urandom;
            iwstrb = 4'($urandom); iwdata = $urandom;
         end
         if (acc_d || !dreq) begin
            dreq = ($urandom_range(0, 2) != 0);
            dwr = $urandom; dsize = 2'($urandom_range(0, 2)); daddr = $urandom;
            dwstrb = 4'($urandom); dwdata = $urandom;
         end
         maok = ($urandom_range(0, 3) != 0);
         mdok = (q.size() > 0) && ($urandom_range(0, 1) == 1);
         mrdata = $urandom;
         cycle();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Shares one SRAM-like memory port (req / addr_ok / data_ok handshake) between the CPU's instruction-fetch requester and data-access requester. It sits between the pipelined core and the memory bridge. It arbitrates address-phase requests, locks a grant until the request is accepted, and tracks outstanding transactions in issue order so each `data_ok` response is routed back to its owner.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 2: maximum accepted-but-unanswered transactions; must be ≥1.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `resetn`  in  1: reset, asynchronous assert, active-low.
- `inst_req`, `inst_wr`  in  1 each: inst requester request / write flag.
- `inst_size`  in  2: 0=byte, 1=half, 2=word.
- `inst_addr`, `inst_wdata`  in  32 each.
- `inst_wstrb`  in  4.
- `inst_addr_ok`, `inst_data_ok`  out  1 each.
- `inst_rdata`  out  32.
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wstrb`, `data_wdata`: same widths as inst.
- `data_addr_ok`, `data_data_ok`  out  1 each.
- `data_rdata`  out  32.
- `mem_req`, `mem_wr`  out  1; `mem_size`  out  2; `mem_addr`, `mem_wdata`  out  32; `mem_wstrb`  out  4.
- `mem_addr_ok`, `mem_data_ok`  in  1; `mem_rdata`  in  32.
- `arb_err`  out  1: sticky flag for a protocol violation.

## Operation
- A transaction is accepted when `mem_req & mem_addr_ok` are both high in the same cycle. A requester must hold req and all payload stable until it sees its `addr_ok`.
- Grant selection, when unlocked:
  - Only one requester active: grant it.
  - Both active: priority rule per Configuration.
- Grant lock:
  - If `mem_req` is high and `mem_addr_ok` is low, record `lock_valid=1` and `lock_owner=granted`.
  - While locked, the locked owner keeps the grant regardless of the other requester.
  - The lock clears on acceptance.
  - If the locked owner drops req, `arb_err` is set and the lock clears.
- Forwarding:
  - `mem_req = granted_req & ~full`.
  - The `mem_*` payload is a mux of the granted requester.
  - `granted_addr_ok = mem_addr_ok & ~full`; the non-granted `addr_ok` is 0.
- Owner FIFO:
  - On acceptance, push the owner (0=inst, 1=data).
  - On `mem_data_ok`, pop the head and pulse that owner's `data_ok`. `mem_rdata` drives both rdata outputs.
  - Responses are strictly in order.
  - `count` ranges 0..`MAX_OUTSTANDING`; full when `count==MAX_OUTSTANDING`.
- Boundary conditions:
  - Simultaneous push and pop: the head is popped, the new entry is appended, and count is unchanged. This is legal even when full: the pop frees a slot in the same cycle, so `full` uses `count - mem_data_ok`.
  - `mem_data_ok` with count 0: ignored, no `data_ok` pulse, `arb_err` set.
  - Pointers wrap modulo `MAX_OUTSTANDING`.
- Reset values (reset asserted mid-transaction): count=0, pointers=0, lock cleared, `last_grant`=inst, `arb_err`=0. All `addr_ok` and `data_ok` outputs and `mem_req` are 0 while reset is low. Responses arriving after reset for pre-reset transactions follow the empty-FIFO rule.

## Timing
- The request path is combinational: requester req to `mem_req`, and `mem_addr_ok` to the requester's `addr_ok`, in the same cycle.
- The response path is combinational: `mem_data_ok` to the owner's `data_ok` in the same cycle, 0 added latency.
- FIFO, lock, `last_grant` and `arb_err` update on the clock edge following the event.
- Earliest response is in the cycle after acceptance. A same-cycle response is not allowed; if it occurs with an empty FIFO, `arb_err` is set.
- Throughput: one acceptance per cycle while not full.

## Configuration
- `SRAM_ARB_ROUND_ROBIN_EN` defined:
  - `last_grant` register updates on each acceptance.
  - When both requesters are active and unlocked, grant goes to the owner not in `last_grant`.
- `SRAM_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: data beats inst.
  - `last_grant` is not implemented.

## Structure
- Package `sram_arb_pkg`:
  - Owner encoding `OWN_INST=1'b0`, `OWN_DATA=1'b1`.
  - Size constants `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`.
- Sub-module `owner_fifo`: 1-bit-wide, `MAX_OUTSTANDING`-deep circular FIFO with push/pop/count/full/empty and the async active-low reset.

## Test plan
- Single inst read at addr 0x1c000000, `mem_addr_ok`=1, response 0x02800000 one cycle later → `inst_addr_ok` pulses the same cycle as req; `inst_data_ok` with `inst_rdata`=0x02800000; data side silent.
- Both requesters high continuously, `mem_addr_ok`=1:
  - Without the macro: data granted every cycle and inst starved.
  - With the macro: grants alternate D, I, D, I…
- Inst req with `mem_addr_ok` low for 3 cycles while data req rises in cycle 2 → grant stays inst until acceptance in cycle 4; data is accepted in cycle 5.
- `MAX_OUTSTANDING`=2: two accepted reads with no response → `mem_req`=0 and both `addr_ok` 0. On `mem_data_ok` in the same cycle as a pending third req, the third is accepted and count stays 2.
- Issue data write (wstrb 0xF, wdata 0xDEADBEEF) then inst read; responses return in that order → `data_data_ok` first, then `inst_data_ok`.
- `mem_data_ok` with empty FIFO → no `data_ok` pulse and `arb_err`=1 held. Then `resetn` low → `arb_err`=0, count=0.
